// File: rtl/div_unit.sv
// Multi-cycle restoring divider beside the ex stage. It supports signed and unsigned
// operands and can be annulled while a divide is in flight.
// Optional build macro DIV_EARLY_ZERO_EN: a zero dividend completes in 2 edges instead of WIDTH+2.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {StFree, StDivByZero, StOn, StEnd} state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_neg_quo;
    logic               r_neg_rem;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_op1_mag;
    logic [WIDTH-1:0]   w_op2_mag;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic               w_zero_path;

    assign w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign w_op1_mag = w_op1_neg ? -opdata1_i : opdata1_i;
    assign w_op2_mag = w_op2_neg ? -opdata2_i : opdata2_i;

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
    // and the top bit of the difference is the borrow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};

    assign w_quo_fix = r_neg_quo ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_rem ? -r_rem : r_rem;

`ifdef DIV_EARLY_ZERO_EN
    assign w_zero_path = (opdata2_i == '0) || (opdata1_i == '0);
`else
    assign w_zero_path = (opdata2_i == '0);
`endif

    assign busy_o = (r_state == StDivByZero) || (r_state == StOn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StFree;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            unique case (r_state)
                StFree: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (w_zero_path) begin
                            r_state <= StDivByZero;
                        end else begin
                            r_state   <= StOn;
                            r_cnt     <= '0;
                            r_rem     <= '0;
                            r_quo     <= w_op1_mag;
                            r_divisor <= w_op2_mag;
                            r_neg_quo <= w_op1_neg ^ w_op2_neg;
                            r_neg_rem <= w_op1_neg;
                        end
                    end
                end
                StDivByZero: begin
                    r_state  <= StEnd;
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                StOn: begin
                    if (annul_i) begin
                        r_state  <= StFree;
                        r_cnt    <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else if (r_cnt != LastCnt) begin
                        r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_state  <= StEnd;
                        result_o <= {w_rem_fix, w_quo_fix};
                        ready_o  <= 1'b1;
                    end
                end
                StEnd: begin
                    if (!start_i) begin
                        r_state  <= StFree;
                        r_cnt    <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: r_state <= StFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results are queued at issue and checked on ready_o.
module tb_div_unit;

    localparam int unsigned WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              signed_div_i = 1'b0;
    logic [WIDTH-1:0]  opdata1_i = '0;
    logic [WIDTH-1:0]  opdata2_i = '0;
    logic              start_i = 1'b0;
    logic              annul_i = 1'b0;
    logic [2*WIDTH-1:0] result_o;
    logic              ready_o;
    logic              busy_o;

    int n_vec = 0;
    int n_err = 0;
    logic [2*WIDTH-1:0] sb_q[$];

`ifdef DIV_EARLY_ZERO_EN
    localparam int ZeroDivLat = 1;
`else
    localparam int ZeroDivLat = 33;
`endif

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    // Issues one divide, scrambles operands after the sampling edge, and checks latency,
    // busy duration, result, hold-while-start and release.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat);
        int lat = 0;
        int nbusy = 0;
        logic [63:0] exp;
        sb_q.push_back(model(sgn, a, b));
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~sgn;
        if (busy_o) nbusy++;
        while (!ready_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            check({tag, "_excl"}, {63'h0, busy_o & ready_o}, 64'h0);
            if (busy_o) nbusy++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy"}, 64'(nbusy), 64'(exp_lat));
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hDEAD;
        check({tag, "_res"}, result_o, exp);
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rel"}, {ready_o, result_o[62:0]}, 64'h0);
    endtask

    initial begin
        int saw_ready;
        #2;
        check("rst_out", {busy_o, ready_o, result_o[61:0]}, 64'h0);
        #10 rst = 1'b0;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 33);
        do_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        do_div("dz_u", 1'b0, 32'd55, 32'd0, 1);
        do_div("dz_s", 1'b1, 32'hFFFF_0000, 32'd0, 1);
        do_div("u_big", 1'b0, 32'hFFFF_FFFF, 32'd1, 33);
        do_div("s_pn", 1'b1, 32'd1000, 32'hFFFF_FFF9, 33);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom_range(1, 32'hFFFF);
            do_div($sformatf("rnd%0d", i), i[0], ra, rb, 33);
        end

        // Annul at iteration 10.
        saw_ready = 0;
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ready_o) saw_ready = 1;
        end
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul_free", {busy_o, ready_o, result_o[61:0]}, 64'h0);
        check("annul_nordy", 64'(saw_ready), 64'h0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        do_div("u9_3", 1'b0, 32'd9, 32'd3, 33);

        // Asynchronous reset mid-divide.
        @(negedge clk);
        opdata1_i = 32'd123;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_out", {busy_o, ready_o, result_o[61:0]}, 64'h0);
        #1;
        start_i = 1'b0;
        rst     = 1'b0;
        do_div("u50_5", 1'b0, 32'd50, 32'd5, 33);

        do_div("zero_dvd", 1'b0, 32'd0, 32'd5, ZeroDivLat);

        if (sb_q.size() != 0) check("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised multi-cycle restoring divider that sits beside the ex stage.
- ex holds start_i high and raises its stall request until ready_o is asserted; the ex/mem stage then writes {remainder, quotient} to the HI/LO path.
- Generalises the stall-driven multi-cycle ex path: operand width is a parameter, signed and unsigned modes are supported, and a pending divide can be annulled when the divide sits in a flushed delay-slot/branch shadow.

Parameters:
WIDTH, 32, operand width in bits; result width is 2*WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
signed_div_i  in  1  1 = two's-complement divide (DIV), 0 = unsigned (DIVU).
opdata1_i  in  WIDTH  dividend.
opdata2_i  in  WIDTH  divisor.
start_i  in  1  request; held high by ex for the whole operation.
annul_i  in  1  abort the in-flight divide.
result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
ready_o  out  1  result_o is valid.
busy_o  out  1  high in DIVBYZERO and ON states.

Behaviour:
- Reset (asynchronous, any state): state <= FREE, cnt <= 0, result_o <= 0, ready_o <= 0, internal registers <= 0.
- States: FREE, DIVBYZERO, ON, END. Encoding is free.
- FREE, start_i=1 and annul_i=0:
  - opdata2_i==0 -> DIVBYZERO.
  - Otherwise, latch operands and go to ON with cnt=0.
  - Signed mode: negative operands are latched as their two's-complement magnitudes, and the original sign bits are latched.
- FREE, start_i=1 and annul_i=1: stay in FREE.
- FREE, start_i=0: stay in FREE; ready_o=0, result_o=0.
- DIVBYZERO: next edge -> END with result_o=0.
- ON, annul_i=0, cnt<WIDTH: one restoring step per edge.
  - Shift the {partial remainder, dividend} register left by 1.
  - Subtract the divisor using a (WIDTH+1)-bit subtraction.
  - Non-negative difference: keep it and shift in quotient bit 1. Negative difference: restore and shift in 0.
  - cnt++.
- ON, cnt==WIDTH:
  - Signed mode: negate the quotient if the latched signs differ; negate the remainder if the dividend was negative.
  - Load result_o, set ready_o=1, go to END.
- ON, annul_i=1 (takes priority over stepping): next edge -> FREE, ready_o=0, result_o=0, cnt=0.
- END: ready_o=1 and result_o stay stable while start_i=1. When start_i=0, next edge -> FREE, ready_o=0, result_o=0.
- annul_i is ignored in DIVBYZERO and END.
- Latency, start_i sampled at edge e0 in FREE:
  - Normal divide: ready_o high after edge e(WIDTH+1), i.e. 33 edges for WIDTH=32.
  - Divide by zero: ready_o high after edge e1.
- Overflow case (signed, most-negative / -1): quotient = most-negative value (wraps), remainder = 0. No flag is raised.
- Operand changes after the start_i sampling edge have no effect on the in-flight divide.
- busy_o and ready_o are never high together.

Optional Feature:
- Macro: DIV_EARLY_ZERO_EN.
- Defined: in FREE with start_i=1, annul_i=0, opdata1_i==0 and opdata2_i!=0, go to DIVBYZERO-equivalent handling; END is reached after 1 edge with result_o=0. Latency is 2 edges instead of WIDTH+2.
- Undefined: a zero dividend runs the full WIDTH iterations and produces result_o=0 after edge e(WIDTH+1).
- All other behaviour is identical in both builds.

Test Plan:
1. WIDTH=32, unsigned, 100 / 7, start held -> ready_o rises after edge 33; result_o = {32'h2, 32'hE}. ready_o stays high while start_i=1, then drops one edge after start_i falls.
2. Signed, -7 / 2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Signed, 32'h80000000 / 32'hFFFFFFFF -> {32'h0, 32'h80000000}.
3. Divisor = 0, any mode -> busy_o high for 1 cycle; ready_o after edge 1; result_o = 0.
4. Start 100 / 7, assert annul_i at iteration 10 -> FREE on the next edge; ready_o never asserts. A new start 9 / 3 is accepted immediately and gives {0, 3} after 33 edges.
5. Assert rst asynchronously mid-ON (between edges) -> outputs go to 0 immediately, without waiting for a clock edge; after release, a new 50 / 5 completes correctly as {0, 10}.
6. Dividend = 0, divisor = 5 -> with DIV_EARLY_ZERO_EN, ready_o after edge 1 with result 0; without it, ready_o after edge 33 with result 0.
